lc3_mem_ctrl: RTL and testbench
===============================

// Module: lc3_mem_ctrl
// PURPOSE
//  Parametrised LC-3 memory controller between the CPU datapath and a word-addressed RAM.
//  - Owns the MAR.
//  - Inserts a configurable number of wait states and signals completion with a ready (R) pulse.
//  - Decodes the LC-3 memory-mapped keyboard/display registers (KBSR/KBDR/DSR/DDR).
//  - Adds over the earlier fixed 16-bit memory hookup: variable latency, bounded RAM depth, device I/O.
// PARAMETERS
//  DATA_W       16       data word width
//  ADDR_W       16       address / MAR width
//  DEPTH_W      12       implemented RAM = 2**DEPTH_W words; higher non-MMIO addresses unbacked
//  WAIT_STATES  2        extra cycles per access, legal range 0..15
//  MMIO_BASE    16'hFE00 base address of the I/O page (KBSR +0, KBDR +2, DSR +4, DDR +6)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset; asynchronous, active-high
//  ldMAR       in   1       load MAR from addr
//  addr        in   ADDR_W  address from datapath
//  mem_en      in   1       access request (MIO.EN), sampled in IDLE only
//  memWE       in   1       1 = write, 0 = read; sampled with mem_en
//  data_in     in   DATA_W  write data from datapath, sampled with mem_en
//  data_out    out  DATA_W  read data (MDR source)
//  mem_ready   out  1       one-cycle completion pulse (R)
//  kb_valid    in   1       keyboard byte strobe
//  kb_data     in   8       keyboard byte
//  disp_valid  out  1       display byte pending
//  disp_data   out  8       display byte
//  disp_ack    in   1       display consumed byte
// BEHAVIOUR
//  Reset (async, any state):
//  - FSM to IDLE; mar, data_out, mem_ready, disp_valid, disp_data, kb_full, kb_buf all 0.
//  - RAM contents not cleared.
//  - An access in flight is abandoned: no write commits, no ready pulse.
//  MAR:
//  - mar <= addr on ldMAR, only in IDLE.
//  - ldMAR in WAIT/DONE is ignored, so MAR is stable for the whole access.
//  FSM IDLE -> WAIT -> DONE -> IDLE:
//  - IDLE & mem_en: latch memWE and data_in. Go to WAIT with cnt = WAIT_STATES-1, or to DONE if WAIT_STATES == 0.
//  - WAIT: decrement cnt; go to DONE when cnt == 0.
//  - DONE: mem_ready = 1 for exactly this cycle; read result registered into data_out; write committed; return to IDLE.
//  - Latency: mem_ready rises WAIT_STATES+1 cycles after the edge sampling mem_en.
//  - mem_en is ignored outside IDLE. Back-to-back access period is WAIT_STATES+2 cycles.
//  - data_out holds its value until the next read completes; writes leave it unchanged.
//  Decode (on mar):
//  - mar < 2**DEPTH_W: RAM.
//  - MMIO_BASE <= mar <= MMIO_BASE+6 (even offsets): registers below.
//  - All other addresses: reads return 0, writes ignored.
//  MMIO registers:
//  - KBSR read = {kb_full, 0...}.
//  - KBDR read = {0..., kb_buf}; clears kb_full in DONE.
//  - kb_valid with !kb_full: kb_buf <= kb_data, kb_full <= 1. kb_valid with kb_full: byte dropped (overrun).
//  - KBDR read completion in the same cycle as kb_valid: read returns the old byte, the new byte is loaded, kb_full stays 1.
//  - DSR read = {~disp_valid, 0...}.
//  - DDR write with !disp_valid: disp_data <= data_in[7:0], disp_valid <= 1. DDR write while disp_valid=1: dropped.
//  - disp_ack clears disp_valid; if it coincides with a DDR write, the ack clears first and the write then loads.
//  - MMIO writes to KBSR/KBDR/DSR are ignored; DDR reads return 0.
// STRUCTURE
//  - Package lc3_mem_pkg: state enum {IDLE,WAIT,DONE}; MMIO offset localparams; default width constants.
//  - Sub-module lc3_mmio_regs: keyboard/display registers, plus read mux and write strobes from the decode.
//  - RAM: behavioural array inside lc3_mem_ctrl.
// TESTING
//  1. WAIT_STATES=2: ldMAR addr=x0010, write xBEEF; then read x0010 -> mem_ready 3 cycles after mem_en, data_out=xBEEF.
//  2. WAIT_STATES=0: alternate writes/reads x0000..x0003, one access per 2 cycles -> each read returns the value last written.
//  3. Read x3000 with DEPTH_W=12 -> data_out=0; write x3000=x1234 then read x0000 -> RAM word x0000 unchanged.
//  4. kb_valid 'A'(x41), then 'B' -> KBSR=x8000, KBDR=x0041 ('B' dropped); next KBSR read = x0000.
//  5. DDR write x0048 -> disp_valid=1, disp_data=x48, DSR=x0000; 2nd DDR write dropped; disp_ack -> DSR=x8000.
//  6. rst pulsed mid-WAIT of a write to x0020 -> no mem_ready, word x0020 unchanged, mar=0, FSM in IDLE next cycle.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared state encoding, MMIO register offsets and default widths for the LC-3 memory controller.
package lc3_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int KBSR_OFF = 0;
  localparam int KBDR_OFF = 2;
  localparam int DSR_OFF = 4;
  localparam int DDR_OFF = 6;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH_W = 12;
  localparam int DEF_WAIT_STATES = 2;
  localparam logic [15:0] DEF_MMIO_BASE = 16'hFE00;
endpackage

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: keyboard/display device registers with their read mux and access-completion write strobes.
import lc3_mem_pkg::*;
module lc3_mmio_regs #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DEF_MMIO_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_stb,
  input  logic              wr_stb,
  input  logic [7:0]        wdata,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  input  logic              disp_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              disp_valid,
  output logic [7:0]        disp_data
);
  logic       kb_full;
  logic [7:0] kb_buf;
  logic       sel_kbsr, sel_kbdr, sel_dsr, sel_ddr, kb_rd, ddr_wr;
  assign sel_kbsr = addr == MMIO_BASE + ADDR_W'(KBSR_OFF);
  assign sel_kbdr = addr == MMIO_BASE + ADDR_W'(KBDR_OFF);
  assign sel_dsr  = addr == MMIO_BASE + ADDR_W'(DSR_OFF);
  assign sel_ddr  = addr == MMIO_BASE + ADDR_W'(DDR_OFF);
  assign kb_rd    = rd_stb && sel_kbdr;
  assign ddr_wr   = wr_stb && sel_ddr;
  assign rdata = sel_kbsr ? {kb_full, {(DATA_W-1){1'b0}}} :
                 sel_kbdr ? {{(DATA_W-8){1'b0}}, kb_buf} :
                 sel_dsr  ? {~disp_valid, {(DATA_W-1){1'b0}}} : '0;
  // a byte arriving as KBDR is consumed replaces it and keeps the buffer full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      kb_full <= 1'b0;
      kb_buf  <= '0;
    end else if (kb_valid && (!kb_full || kb_rd)) begin
      kb_buf  <= kb_data;
      kb_full <= 1'b1;
    end else if (kb_rd) kb_full <= 1'b0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else if (ddr_wr && (!disp_valid || disp_ack)) begin
      disp_data  <= wdata;
      disp_valid <= 1'b1;
    end else if (disp_ack) disp_valid <= 1'b0;
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: MAR, wait-state sequencer, bounded RAM and MMIO decode between the LC-3 datapath and memory.
import lc3_mem_pkg::*;
module lc3_mem_ctrl #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH_W = DEF_DEPTH_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DEF_MMIO_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ldMAR,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_en,
  input  logic              memWE,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_ready,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              disp_ack
);
  state_t            state;
  logic [3:0]        cnt;
  logic              we_q, in_ram, rd_stb, wr_stb;
  logic [DATA_W-1:0] wd_q, io_rdata, rd_data;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ram [2**DEPTH_W];
  assign in_ram  = (mar >> DEPTH_W) == '0;
  assign rd_stb  = state == DONE && !we_q;
  assign wr_stb  = state == DONE && we_q;
  assign rd_data = in_ram ? ram[mar[DEPTH_W-1:0]] : io_rdata;
  always_ff @(posedge clk)
    if (wr_stb && in_ram) ram[mar[DEPTH_W-1:0]] <= wd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      mar       <= '0;
      data_out  <= '0;
      mem_ready <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ldMAR) mar <= addr;
          if (mem_en) begin
            we_q  <= memWE;
            wd_q  <= data_in;
            cnt   <= 4'(WAIT_STATES - 1);
            state <= WAIT_STATES == 0 ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= DONE;
        end
        DONE: begin
          mem_ready <= 1'b1;
          if (!we_q) data_out <= rd_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  lc3_mmio_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE)) u_mmio (
    .clk(clk),
    .rst(rst),
    .addr(mar),
    .rd_stb(rd_stb),
    .wr_stb(wr_stb),
    .wdata(wd_q[7:0]),
    .kb_valid(kb_valid),
    .kb_data(kb_data),
    .disp_ack(disp_ack),
    .rdata(io_rdata),
    .disp_valid(disp_valid),
    .disp_data(disp_data)
  );
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed bench with a transaction-level memory/device model checked every cycle.
module tb_lc3_mem_ctrl;
  import lc3_mem_pkg::*;
  localparam int WS = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic ldMAR = 0, mem_en = 0, memWE = 0, kb_valid = 0, disp_ack = 0;
  logic [15:0] addr = 0, data_in = 0, data_out;
  logic [7:0] kb_data = 0, disp_data;
  logic mem_ready, disp_valid;
  logic b_ld = 0, b_en = 0, b_we = 0, b_rdy, b_dv, zero = 0;
  logic [15:0] b_addr = 0, b_din = 0, b_dout;
  logic [7:0] b_dd, zero8 = 0;
  int checks = 0, failures = 0;

  lc3_mem_ctrl u0 (.clk(clk), .rst(rst), .ldMAR(ldMAR), .addr(addr), .mem_en(mem_en), .memWE(memWE),
    .data_in(data_in), .data_out(data_out), .mem_ready(mem_ready), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack));
  lc3_mem_ctrl #(.WAIT_STATES(0)) u1 (.clk(clk), .rst(rst), .ldMAR(b_ld), .addr(b_addr), .mem_en(b_en),
    .memWE(b_we), .data_in(b_din), .data_out(b_dout), .mem_ready(b_rdy), .kb_valid(zero), .kb_data(zero8),
    .disp_valid(b_dv), .disp_data(b_dd), .disp_ack(zero));

  function automatic void check(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endfunction

  // Model: an accepted access completes WS+1 edges later; device state follows the register rules directly.
  logic [15:0] mem [int];
  bit busy, m_we, m_ready, m_kbf, m_dv;
  int left;
  logic [15:0] m_d, m_mar, m_dout;
  logic [7:0] m_kb, m_dd;
  always @(posedge clk) begin
    bit kb_rd, ddr_wr;
    if (rst) begin
      busy = 0; m_ready = 0; m_dout = 0; m_mar = 0; m_kbf = 0; m_kb = 0; m_dv = 0; m_dd = 0;
    end else begin
      kb_rd = 0; ddr_wr = 0; m_ready = 0;
      if (busy) begin
        left--;
        if (left == 0) begin
          busy = 0; m_ready = 1;
          if (m_we) begin
            if (m_mar < 16'h1000) mem[int'(m_mar)] = m_d;
            ddr_wr = m_mar == 16'hFE06;
          end else begin
            m_dout = m_mar < 16'h1000 ? mem[int'(m_mar)] : m_mar == 16'hFE00 ? {m_kbf, 15'h0} :
                     m_mar == 16'hFE02 ? {8'h0, m_kb} : m_mar == 16'hFE04 ? {~m_dv, 15'h0} : 16'h0;
            kb_rd = m_mar == 16'hFE02;
          end
        end
      end else begin
        if (ldMAR) m_mar = addr;
        if (mem_en) begin busy = 1; left = WS + 1; m_we = memWE; m_d = data_in; end
      end
      if (kb_valid && (!m_kbf || kb_rd)) begin m_kb = kb_data; m_kbf = 1; end
      else if (kb_rd) m_kbf = 0;
      if (disp_ack) m_dv = 0;
      if (ddr_wr && !m_dv) begin m_dd = m_d[7:0]; m_dv = 1; end
    end
  end

  always @(negedge clk)
    if (!rst) begin
      check("ready", mem_ready, m_ready);
      check("dout", data_out, m_dout);
      check("dvalid", disp_valid, m_dv);
      check("ddata", disp_data, m_dd);
      check("mar", u0.mar, m_mar);
    end

  // ev: 1 = keyboard byte, 2 = display ack, both landing on the completion edge
  task automatic acc(input bit we, input logic [15:0] a, d, input int ev, input logic [7:0] evd,
                     output logic [15:0] rd, output int lat);
    ldMAR = 1; addr = a; mem_en = 1; memWE = we; data_in = d;
    @(negedge clk); ldMAR = 0; mem_en = 0; lat = 0;
    while (!mem_ready && lat < 20) begin
      if (lat == 1) begin ldMAR = 1; addr = 16'h0777; end
      if (lat == 2 && ev == 1) begin kb_valid = 1; kb_data = evd; end
      if (lat == 2 && ev == 2) disp_ack = 1;
      @(negedge clk); ldMAR = 0; kb_valid = 0; disp_ack = 0; lat++;
    end
    rd = data_out;
  endtask
  task automatic wr(input logic [15:0] a, d);
    logic [15:0] r; int l;
    acc(1, a, d, 0, 0, r, l);
    check("wr_lat", l, WS + 1);
  endtask
  task automatic rdx(input string n, input logic [15:0] a, exp);
    logic [15:0] r; int l;
    acc(0, a, 0, 0, 0, r, l);
    check(n, r, exp);
    check("rd_lat", l, WS + 1);
  endtask
  task automatic acc1(input bit we, input logic [15:0] a, d, output logic [15:0] rd, output int lat);
    b_ld = 1; b_addr = a; b_en = 1; b_we = we; b_din = d;
    @(negedge clk); b_ld = 0; b_en = 0; lat = 0;
    while (!b_rdy && lat < 20) begin @(negedge clk); lat++; end
    rd = b_dout;
  endtask
  task automatic kb_byte(input logic [7:0] b);
    kb_valid = 1; kb_data = b;
    @(negedge clk); kb_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] r;
    int l;
    repeat (2) @(negedge clk);
    check("rst_dout", data_out, 0);
    check("rst_ready", mem_ready, 0);
    check("rst_dvalid", disp_valid, 0);
    check("rst_ddata", disp_data, 0);
    check("rst_mar", u0.mar, 0);
    check("rst_state", u0.state, IDLE);
    #2 rst = 0;
    @(negedge clk);
    wr(16'h0010, 16'hBEEF);
    rdx("t1_read", 16'h0010, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      acc1(1, 16'(i), 16'hA0 + 16'(i), r, l);
      check("t2_wr_lat", l, 1);
      acc1(0, 16'(i), 16'h0, r, l);
      check("t2_rd_lat", l, 1);
      check("t2_read", r, 16'hA0 + 16'(i));
    end
    check("t2_no_disp", b_dv, 0);
    wr(16'h0000, 16'h1111);
    rdx("t3_unbacked", 16'h3000, 16'h0000);
    wr(16'h3000, 16'h1234);
    rdx("t3_ram0", 16'h0000, 16'h1111);
    rdx("t3_ram10", 16'h0010, 16'hBEEF);
    kb_byte(8'h41);
    kb_byte(8'h42);
    rdx("t4_kbsr_full", 16'hFE00, 16'h8000);
    rdx("t4_kbdr", 16'hFE02, 16'h0041);
    rdx("t4_kbsr_empty", 16'hFE00, 16'h0000);
    kb_byte(8'h43);
    acc(0, 16'hFE02, 0, 1, 8'h44, r, l);
    check("t4_kbdr_race_old", r, 16'h0043);
    rdx("t4_kbsr_race", 16'hFE00, 16'h8000);
    rdx("t4_kbdr_race_new", 16'hFE02, 16'h0044);
    wr(16'hFE00, 16'hFFFF);
    rdx("t4_kbsr_ro", 16'hFE00, 16'h0000);
    wr(16'hFE06, 16'h0048);
    check("t5_dvalid", disp_valid, 1);
    check("t5_ddata", disp_data, 8'h48);
    rdx("t5_dsr_busy", 16'hFE04, 16'h0000);
    wr(16'hFE06, 16'h0049);
    check("t5_drop", disp_data, 8'h48);
    disp_ack = 1;
    @(negedge clk); disp_ack = 0;
    rdx("t5_dsr_free", 16'hFE04, 16'h8000);
    rdx("t5_ddr_read", 16'hFE06, 16'h0000);
    wr(16'hFE06, 16'h0050);
    acc(1, 16'hFE06, 16'h0055, 2, 0, r, l);
    check("t5_ack_write_v", disp_valid, 1);
    check("t5_ack_write_d", disp_data, 8'h55);
    wr(16'h0020, 16'h5A5A);
    ldMAR = 1; addr = 16'h0020; mem_en = 1; memWE = 1; data_in = 16'hDEAD;
    @(negedge clk); ldMAR = 0; mem_en = 0;
    #2 rst = 1;
    #1 check("t6_state", u0.state, IDLE);
    check("t6_mar", u0.mar, 0);
    @(negedge clk);
    check("t6_no_ready", mem_ready, 0);
    #2 rst = 0;
    @(negedge clk);
    check("t6_idle", u0.state, IDLE);
    rdx("t6_word", 16'h0020, 16'h5A5A);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
